// File: rtl/axi_line_refill_master.sv
// AXI4 read master for L1 line refills: one miss becomes one INCR burst of BEATS words,
// assembled into a line and handed back with a single-cycle valid pulse.
module axi_line_refill_master #(
    parameter logic [3:0]  MASTER_ID = 4'b0000,
    parameter int unsigned BEATS     = 4,
    parameter int unsigned LINE_W    = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       req_addr,
    output logic              busy,
    output logic              line_valid,
    output logic [LINE_W-1:0] line_data,
    output logic              line_err,
    output logic [3:0]        ARID_M,
    output logic [31:0]       ARADDR_M,
    output logic [3:0]        ARLEN_M,
    output logic [2:0]        ARSIZE_M,
    output logic [1:0]        ARBURST_M,
    output logic              ARVALID_M,
    input  logic              ARREADY_M,
    input  logic [3:0]        RID_M,
    input  logic [31:0]       RDATA_M,
    input  logic [1:0]        RRESP_M,
    input  logic              RLAST_M,
    input  logic              RVALID_M,
    output logic              RREADY_M
);

    localparam int unsigned CntW      = $clog2(BEATS);
    localparam logic [CntW-1:0] CntMax = CntW'(BEATS - 1);
    localparam logic [31:0] AlignMask = ~32'(4 * BEATS - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e            r_state, w_state_d;
    logic [31:0]       r_addr, w_addr_d;
    logic [LINE_W-1:0] r_line, w_line_d;
    logic              r_err, w_err_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic              w_cnt_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_line  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_addr  <= w_addr_d;
            r_line  <= w_line_d;
            r_err   <= w_err_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign w_cnt_last = (r_cnt == CntMax);

    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        w_line_d  = r_line;
        w_err_d   = r_err;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (req) begin
                    w_addr_d  = req_addr & AlignMask;
                    w_line_d  = '0;
                    w_err_d   = 1'b0;
                    w_cnt_d   = '0;
                    w_state_d = StAddr;
                end
            end
            StAddr: begin
                if (ARREADY_M) begin
                    w_state_d = StData;
                end
            end
            StData: begin
                if (RVALID_M) begin
                    w_line_d[32*int'(r_cnt) +: 32] = RDATA_M;
                    // RLAST must coincide with the final word: early and missing last both flag
                    if (RRESP_M != 2'b00 || RID_M != MASTER_ID || RLAST_M != w_cnt_last) begin
                        w_err_d = 1'b1;
                    end
                    if (RLAST_M || w_cnt_last) begin
                        w_cnt_d   = '0;
                        w_state_d = StDone;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign busy       = (r_state != StIdle);
    assign line_valid = (r_state == StDone);
    assign line_data  = r_line;
    assign line_err   = r_err & (r_state == StDone);
    assign ARID_M     = MASTER_ID;
    assign ARADDR_M   = r_addr;
    assign ARLEN_M    = 4'(BEATS - 1);
    assign ARSIZE_M   = 3'b010;
    assign ARBURST_M  = 2'b01;
    assign ARVALID_M  = (r_state == StAddr);
    assign RREADY_M   = (r_state == StData);

endmodule
